// File: rtl/dm_port_if.sv
// dm_port_if: bundles the CPU requester, DMA requester and SRAM macro
// signals of the data-port arbiter.
//   slave  : arbiter view (requests/addresses/data and sram_dout in;
//            grants, read returns and the SRAM command out)
//   master : environment view (CPU MEM stage, DMA engine and SRAM macro)
`timescale 1ns/1ps
interface dm_port_if #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 32
);
    // CPU MEM stage
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_bweb;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    // DMA / loader engine
    logic              dma_req;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_bweb;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_last;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;
    // SRAM macro
    logic              sram_ceb;
    logic              sram_web;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_bweb;
    logic [DATA_W-1:0] sram_din;
    logic [DATA_W-1:0] sram_dout;

    modport slave (
        input  cpu_req, cpu_addr, cpu_bweb, cpu_wdata,
        input  dma_req, dma_addr, dma_bweb, dma_wdata, dma_last,
        input  sram_dout,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output sram_ceb, sram_web, sram_addr, sram_bweb, sram_din
    );

    modport master (
        output cpu_req, cpu_addr, cpu_bweb, cpu_wdata,
        output dma_req, dma_addr, dma_bweb, dma_wdata, dma_last,
        output sram_dout,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  sram_ceb, sram_web, sram_addr, sram_bweb, sram_din
    );
endinterface

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares one word-addressed data SRAM port between the CPU
// MEM stage and a DMA/loader engine. At most one access per cycle, round-robin
// on ties, DMA bursts locked for up to MAX_BURST beats while the CPU waits.
// Grants and the SRAM command are combinational from the requests; read data
// returns to the owning requester one cycle after its grant.
//   clk, rst : clock (rising edge), synchronous active-high reset
//   bus      : dm_port_if.slave (CPU, DMA and SRAM signals)
`timescale 1ns/1ps
module dm_port_arbiter #(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic       clk,
    input  logic       rst,
    dm_port_if.slave   bus
);
    localparam int unsigned      CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {ARB, BURST} state_t;

    state_t            state, state_n;
    logic              last_gnt, last_gnt_n;   // 0 = CPU, 1 = DMA
    logic [CNT_W-1:0]  beat_cnt, beat_cnt_n;
    logic              cpu_rvalid_q, dma_rvalid_q;
    logic              gnt_cpu, gnt_dma;
    logic              do_arb;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_bweb;
    logic [DATA_W-1:0] win_din;

    // State register and read-return flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ARB;
            last_gnt     <= 1'b1;
            beat_cnt     <= '0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
        end else begin
            state        <= state_n;
            last_gnt     <= last_gnt_n;
            beat_cnt     <= beat_cnt_n;
            cpu_rvalid_q <= gnt_cpu & (&bus.cpu_bweb);
            dma_rvalid_q <= gnt_dma & (&bus.dma_bweb);
        end
    end

    // Next-state and grant decision; no SRAM access is issued during reset
    always_comb begin
        state_n    = state;
        last_gnt_n = last_gnt;
        beat_cnt_n = beat_cnt;
        gnt_cpu    = 1'b0;
        gnt_dma    = 1'b0;
        do_arb     = 1'b0;
        if (!rst) begin
            case (state)
                BURST: begin
                    if (bus.dma_req && (!bus.cpu_req || (beat_cnt < CNT_MAX))) begin
                        gnt_dma = 1'b1;
                        if (beat_cnt < CNT_MAX) begin
                            beat_cnt_n = beat_cnt + CNT_ONE;
                        end
                        if (bus.dma_last) begin
                            state_n    = ARB;
                            beat_cnt_n = '0;
                        end
                    end else begin
                        // Lock expired with CPU waiting, or DMA dropped its request
                        state_n    = ARB;
                        beat_cnt_n = '0;
                        if (bus.dma_req) begin
                            gnt_cpu = 1'b1;
                        end else begin
                            do_arb = 1'b1;
                        end
                    end
                end
                default: do_arb = 1'b1;
            endcase

            // Round-robin: on a tie the side that did not win last time goes
            if (do_arb) begin
                if (bus.cpu_req && (!bus.dma_req || last_gnt)) begin
                    gnt_cpu = 1'b1;
                end else if (bus.dma_req) begin
                    gnt_dma = 1'b1;
                    if (bus.dma_last) begin
                        state_n    = ARB;
                        beat_cnt_n = '0;
                    end else begin
                        state_n    = BURST;
                        beat_cnt_n = CNT_ONE;
                    end
                end
            end

            if (gnt_cpu) begin
                last_gnt_n = 1'b0;
            end else if (gnt_dma) begin
                last_gnt_n = 1'b1;
            end
        end
    end

    // SRAM command mux; idle drives a read-shaped, all-masked, zero command
    always_comb begin
        win_addr = '0;
        win_bweb = '1;
        win_din  = '0;
        if (gnt_cpu) begin
            win_addr = bus.cpu_addr;
            win_bweb = bus.cpu_bweb;
            win_din  = bus.cpu_wdata;
        end else if (gnt_dma) begin
            win_addr = bus.dma_addr;
            win_bweb = bus.dma_bweb;
            win_din  = bus.dma_wdata;
        end
    end

    assign bus.cpu_gnt   = gnt_cpu;
    assign bus.dma_gnt   = gnt_dma;
    assign bus.sram_ceb  = ~(gnt_cpu | gnt_dma);
    assign bus.sram_web  = &win_bweb;
    assign bus.sram_addr = win_addr;
    assign bus.sram_bweb = win_bweb;
    assign bus.sram_din  = win_din;

    // A read in flight when reset arrives is dropped
    assign bus.cpu_rvalid = cpu_rvalid_q & ~rst;
    assign bus.dma_rvalid = dma_rvalid_q & ~rst;
    assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.sram_dout : '0;
    assign bus.dma_rdata  = bus.dma_rvalid ? bus.sram_dout : '0;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: directed scoreboard bench for dm_port_arbiter.
// The driver pushes the expected grant/SRAM command for each cycle and the
// expected read returns; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_dm_port_arbiter;
    localparam int unsigned ADDR_W    = 14;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MAX_BURST = 8;
    localparam logic [31:0] ONES      = 32'hFFFF_FFFF;

    typedef struct packed {
        logic        cg;
        logic        dg;
        logic        ceb;
        logic        web;
        logic [13:0] addr;
        logic [31:0] bweb;
        logic [31:0] din;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    exp_t gq[$];
    rd_t  cpu_q[$];
    rd_t  dma_q[$];

    dm_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    dm_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Word contents returned by the SRAM model
    function automatic logic [31:0] sram_word(input logic [13:0] a);
        if (a == 14'h0010) return 32'hDEAD_BEEF;
        return {8'hC0, 10'h000, a};
    endfunction

    // SRAM macro model: read data one cycle after a read access
    always @(posedge clk) begin
        if (rst) bus_if.sram_dout <= 32'h0;
        else if (!bus_if.sram_ceb && bus_if.sram_web) bus_if.sram_dout <= sram_word(bus_if.sram_addr);
    end

    // Drive one cycle of requests and queue the hand-stated outcome.
    // eg: 0 = no grant, 1 = CPU, 2 = DMA.
    task automatic step(input logic creq, input logic [13:0] caddr, input logic [31:0] cbweb,
                        input logic [31:0] cwdata, input logic dreq, input logic [13:0] daddr,
                        input logic [31:0] dbweb, input logic [31:0] dwdata, input logic dlast,
                        input int eg);
        exp_t e;
        bus_if.cpu_req   = creq;
        bus_if.cpu_addr  = caddr;
        bus_if.cpu_bweb  = cbweb;
        bus_if.cpu_wdata = cwdata;
        bus_if.dma_req   = dreq;
        bus_if.dma_addr  = daddr;
        bus_if.dma_bweb  = dbweb;
        bus_if.dma_wdata = dwdata;
        bus_if.dma_last  = dlast;
        e.cg   = (eg == 1);
        e.dg   = (eg == 2);
        e.ceb  = (eg == 0);
        e.addr = (eg == 1) ? caddr  : (eg == 2) ? daddr  : 14'h0;
        e.bweb = (eg == 1) ? cbweb  : (eg == 2) ? dbweb  : ONES;
        e.din  = (eg == 1) ? cwdata : (eg == 2) ? dwdata : 32'h0;
        e.web  = (e.bweb == ONES);
        gq.push_back(e);
        if (eg == 1 && cbweb == ONES) cpu_q.push_back('{cyc + 1, sram_word(caddr)});
        if (eg == 2 && dbweb == ONES) dma_q.push_back('{cyc + 1, sram_word(daddr)});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 14'h0, ONES, 32'h0, 1'b0, 14'h0, ONES, 32'h0, 1'b0, 0);
    endtask

    // Synchronous reset for n cycles; any read in flight is discarded
    task automatic do_reset(input int n);
        rst = 1'b1;
        bus_if.cpu_req = 1'b0;
        bus_if.dma_req = 1'b0;
        bus_if.dma_last = 1'b0;
        cpu_q.delete();
        dma_q.delete();
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: grant/SRAM command and read returns, sampled mid-cycle
    exp_t mon_e, mon_a;
    rd_t  mon_r;
    logic mon_v;
    always @(negedge clk) begin
        if (gq.size() > 0) begin
            mon_e = gq.pop_front();
            mon_a = {bus_if.cpu_gnt, bus_if.dma_gnt, bus_if.sram_ceb, bus_if.sram_web,
                     bus_if.sram_addr, bus_if.sram_bweb, bus_if.sram_din};
            n_vec++;
            if (mon_a !== mon_e) begin
                n_err++;
                $display("FAIL grant cyc=%0d got cg=%b dg=%b ceb=%b web=%b addr=%h bweb=%h din=%h want cg=%b dg=%b ceb=%b web=%b addr=%h bweb=%h din=%h",
                         cyc, mon_a.cg, mon_a.dg, mon_a.ceb, mon_a.web, mon_a.addr, mon_a.bweb, mon_a.din,
                         mon_e.cg, mon_e.dg, mon_e.ceb, mon_e.web, mon_e.addr, mon_e.bweb, mon_e.din);
            end
        end

        mon_v = (cpu_q.size() > 0) && (cpu_q[0].due == cyc);
        n_vec++;
        if (bus_if.cpu_rvalid !== mon_v) begin
            n_err++;
            $display("FAIL cpu_rvalid cyc=%0d got %b want %b", cyc, bus_if.cpu_rvalid, mon_v);
        end
        mon_r.data = 32'h0;
        if (mon_v) mon_r = cpu_q.pop_front();
        n_vec++;
        if (bus_if.cpu_rdata !== mon_r.data) begin
            n_err++;
            $display("FAIL cpu_rdata cyc=%0d got %h want %h", cyc, bus_if.cpu_rdata, mon_r.data);
        end

        mon_v = (dma_q.size() > 0) && (dma_q[0].due == cyc);
        n_vec++;
        if (bus_if.dma_rvalid !== mon_v) begin
            n_err++;
            $display("FAIL dma_rvalid cyc=%0d got %b want %b", cyc, bus_if.dma_rvalid, mon_v);
        end
        mon_r.data = 32'h0;
        if (mon_v) mon_r = dma_q.pop_front();
        n_vec++;
        if (bus_if.dma_rdata !== mon_r.data) begin
            n_err++;
            $display("FAIL dma_rdata cyc=%0d got %h want %h", cyc, bus_if.dma_rdata, mon_r.data);
        end
    end

    initial begin
        bus_if.cpu_req = 1'b0; bus_if.cpu_addr = 14'h0; bus_if.cpu_bweb = ONES; bus_if.cpu_wdata = 32'h0;
        bus_if.dma_req = 1'b0; bus_if.dma_addr = 14'h0; bus_if.dma_bweb = ONES; bus_if.dma_wdata = 32'h0;
        bus_if.dma_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, no requests: idle command
        idle();

        // CPU read of 0x0010 returns DEADBEEF one cycle later, for one cycle only
        step(1'b1, 14'h0010, ONES, 32'h0, 1'b0, 14'h0, ONES, 32'h0, 1'b0, 1);
        idle();
        idle();

        // Both requesting from reset, single-beat DMA: CPU, DMA, CPU, DMA
        do_reset(1);
        step(1'b1, 14'h0020, ONES, 32'h0, 1'b1, 14'h0030, ONES, 32'h0, 1'b1, 1);
        step(1'b1, 14'h0021, ONES, 32'h0, 1'b1, 14'h0030, ONES, 32'h0, 1'b1, 2);
        step(1'b1, 14'h0021, ONES, 32'h0, 1'b1, 14'h0031, ONES, 32'h0, 1'b1, 1);
        step(1'b1, 14'h0022, ONES, 32'h0, 1'b1, 14'h0031, ONES, 32'h0, 1'b1, 2);
        idle();

        // 12-beat DMA write burst, CPU arrives at beat 3: DMA 1-8, CPU, DMA 9-12
        for (int b = 1; b <= 12; b++) begin
            if (b == 9)
                step(1'b1, 14'h0040, ONES, 32'h0, 1'b1, 14'(32'h100 + b), 32'h0,
                     32'h1000_0000 + 32'(b), 1'b0, 1);
            step((b >= 3) && (b <= 8), 14'h0040, ONES, 32'h0, 1'b1, 14'(32'h100 + b), 32'h0,
                 32'h1000_0000 + 32'(b), (b == 12), 2);
        end
        idle();

        // Lone DMA read burst runs past MAX_BURST; CPU then wins at the saturated count
        for (int b = 1; b <= 10; b++)
            step(1'b0, 14'h0, ONES, 32'h0, 1'b1, 14'(32'h200 + b), ONES, 32'h0, 1'b0, 2);
        step(1'b1, 14'h0041, ONES, 32'h0, 1'b1, 14'h020B, ONES, 32'h0, 1'b0, 1);
        step(1'b0, 14'h0, ONES, 32'h0, 1'b1, 14'h020B, ONES, 32'h0, 1'b1, 2);
        idle();

        // DMA drops its request mid-burst: CPU gets the port in that same cycle
        step(1'b0, 14'h0, ONES, 32'h0, 1'b1, 14'h0280, 32'h0, 32'h5555_0001, 1'b0, 2);
        step(1'b1, 14'h0050, ONES, 32'h0, 1'b0, 14'h0, ONES, 32'h0, 1'b0, 1);
        step(1'b1, 14'h0051, ONES, 32'h0, 1'b1, 14'h0281, 32'h0000_FFFF, 32'h5555_0002, 1'b1, 2);
        step(1'b1, 14'h0051, ONES, 32'h0, 1'b0, 14'h0, ONES, 32'h0, 1'b0, 1);
        idle();

        // CPU byte store: mask and data passed through, write strobe low, no read return
        step(1'b1, 14'h0005, 32'h00FF_FFFF, 32'hAB00_0000, 1'b0, 14'h0, ONES, 32'h0, 1'b0, 1);
        idle();

        // Reset right after a DMA read grant inside a burst
        step(1'b0, 14'h0, ONES, 32'h0, 1'b1, 14'h0300, 32'h0, 32'h7777_0000, 1'b0, 2);
        step(1'b0, 14'h0, ONES, 32'h0, 1'b1, 14'h0301, ONES, 32'h0, 1'b0, 2);
        do_reset(1);
        step(1'b1, 14'h0060, ONES, 32'h0, 1'b1, 14'h0302, ONES, 32'h0, 1'b0, 1);
        step(1'b0, 14'h0, ONES, 32'h0, 1'b1, 14'h0302, ONES, 32'h0, 1'b1, 2);
        idle();
        idle();

        // Every queued read return must have been consumed
        n_vec++;
        if (cpu_q.size() != 0 || dma_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got cpu_q=%0d dma_q=%0d want 0 0", cpu_q.size(), dma_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
